// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - eight-requester round-robin arbiter with registered binary grant
//
// Purpose:
//   Grants one of 2**IDX_W requesters at a time in round-robin order. The grant
//   is presented as a binary index plus valid so that a downstream 3-to-8
//   decoder can build the one-hot enables. Every grant is followed by at least
//   one idle cycle, so two decoded enables can never overlap.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   req            level-sensitive request vector, bit i = requester i
//   release_grant  current owner is done; only looked at while a grant is held
//   grant_valid    grant_idx is valid and owned
//   grant_idx      binary index of the current owner (decoder input)
//   timeout        one-cycle pulse in the first idle cycle after a grant was
//                  revoked by the MAX_HOLD limit
//
// Parameters:
//   IDX_W     grant index width; only 3 (eight requesters) is supported
//   MAX_HOLD  maximum consecutive grant_valid cycles per grant, 0 = unlimited

module rr_arbiter8 #(
  parameter int IDX_W    = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [(1<<IDX_W)-1:0]   req,
  input  logic                    release_grant,
  output logic                    grant_valid,
  output logic [IDX_W-1:0]        grant_idx,
  output logic                    timeout
);

  localparam int N    = 1 << IDX_W;
  // Counter only has to reach MAX_HOLD-1; keep at least one bit when unlimited.
  localparam int HC_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HC_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HC_W'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [HC_W-1:0]  hold_cnt;

  logic [IDX_W-1:0] winner;
  logic             found;
  logic [IDX_W-1:0] cand;

  logic             end_rel;
  logic             end_drop;
  logic             end_hold;

  // Scan ptr, ptr+1, ... with natural IDX_W-bit wrap; first set request wins.
  always_comb begin
    winner = ptr;
    found  = 1'b0;
    cand   = ptr;
    for (int i = 0; i < N; i++) begin
      cand = ptr + IDX_W'(i);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    end_rel  = release_grant;
    end_drop = !req[grant_idx];
    end_hold = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      hold_cnt    <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      timeout     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // timeout only ever lives for the first idle cycle after a revocation.
          timeout <= 1'b0;
          if (found) begin
            grant_idx   <= winner;
            grant_valid <= 1'b1;
            hold_cnt    <= '0;
            state       <= GRANT;
          end
        end
        GRANT: begin
          if (end_rel || end_drop || end_hold) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            // Previous owner drops to lowest priority for the next round.
            ptr         <= grant_idx + IDX_W'(1);
            timeout     <= end_hold && !end_rel && !end_drop;
          end else begin
            timeout <= 1'b0;
            if (MAX_HOLD != 0) begin
              hold_cnt <= hold_cnt + HC_W'(1);
            end
          end
        end
        default: begin
          state       <= IDLE;
          grant_valid <= 1'b0;
          timeout     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb/tb_rr_arbiter8.sv - self-checking bench for rr_arbiter8

module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic       rel = 1'b0;

  logic       gv_a, to_a;
  logic [2:0] idx_a;
  logic       gv_b, to_b;
  logic [2:0] idx_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rr_arbiter8 #(.IDX_W(3), .MAX_HOLD(4)) u_a (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .release_grant (rel),
    .grant_valid   (gv_a),
    .grant_idx     (idx_a),
    .timeout       (to_a)
  );

  rr_arbiter8 #(.IDX_W(3), .MAX_HOLD(0)) u_b (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .release_grant (rel),
    .grant_valid   (gv_b),
    .grant_idx     (idx_b),
    .timeout       (to_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: owner = -1 when idle, held = grant_valid cycles seen so far,
  // last = previous owner (7 after reset so requester 0 has top priority).
  int owner[2]   = '{-1, -1};
  int held[2]    = '{0, 0};
  int last[2]    = '{7, 7};
  int mh[2]      = '{4, 0};
  bit exp_gv[2]  = '{0, 0};
  int exp_idx[2] = '{0, 0};
  bit exp_to[2]  = '{0, 0};

  task automatic model_step(input int m);
    int pick;
    bit dropped;
    bit limit;
    if (owner[m] < 0) begin
      exp_to[m] = 0;
      pick = -1;
      for (int k = 1; k <= 8; k++) begin
        if (pick < 0 && req[(last[m] + k) % 8]) pick = (last[m] + k) % 8;
      end
      if (pick >= 0) begin
        owner[m]   = pick;
        held[m]    = 1;
        exp_gv[m]  = 1;
        exp_idx[m] = pick;
      end
    end else begin
      dropped = !req[owner[m]];
      limit   = (mh[m] != 0) && (held[m] == mh[m]);
      if (rel || dropped || limit) begin
        exp_to[m] = limit && !rel && !dropped;
        last[m]   = owner[m];
        owner[m]  = -1;
        exp_gv[m] = 0;
      end else begin
        exp_to[m] = 0;
        held[m]++;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int m = 0; m < 2; m++) begin
        owner[m] = -1; held[m] = 0; last[m] = 7;
        exp_gv[m] = 0; exp_idx[m] = 0; exp_to[m] = 0;
      end
    end else begin
      model_step(0);
      model_step(1);
    end
  end

  always @(negedge clk) begin
    check("a_gv",  {31'd0, gv_a},  {31'd0, exp_gv[0]});
    check("a_idx", {29'd0, idx_a}, exp_idx[0]);
    check("a_to",  {31'd0, to_a},  {31'd0, exp_to[0]});
    check("b_gv",  {31'd0, gv_b},  {31'd0, exp_gv[1]});
    check("b_idx", {29'd0, idx_b}, exp_idx[1]);
    check("b_to",  {31'd0, to_b},  {31'd0, exp_to[1]});
  end

  task automatic wait_grant(input string tag);
    int n = 0;
    while (gv_a !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (gv_a !== 1'b1) check({tag, "_wait"}, {31'd0, gv_a}, 32'd1);
  endtask

  initial begin
    int cnt;

    // Reset with all requesting.
    req = 8'hFF;
    repeat (3) @(negedge clk);
    check("rst_gv",  {31'd0, gv_a},  32'd0);
    check("rst_idx", {29'd0, idx_a}, 32'd0);
    check("rst_to",  {31'd0, to_a},  32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_gv",  {31'd0, gv_a},  32'd1);
    check("first_idx", {29'd0, idx_a}, 32'd0);

    // Rotation 0..7,0..5 with one-cycle bubbles; switch req to 0000_0101 at owner 5.
    for (int n = 0; n < 14; n++) begin
      wait_grant("rot");
      check("rot_idx", {29'd0, idx_a}, n % 8);
      if (n == 13) req = 8'h05;
      rel = 1'b1;
      @(negedge clk);
      rel = 1'b0;
      check("bubble_gv", {31'd0, gv_a}, 32'd0);
      @(negedge clk);
      check("regrant_gv", {31'd0, gv_a}, 32'd1);
    end
    check("wrap_idx", {29'd0, idx_a}, 32'd0);
    rel = 1'b1;
    @(negedge clk);
    rel = 1'b0;
    wait_grant("skip");
    check("skip_idx", {29'd0, idx_a}, 32'd2);
    req = 8'h08;
    rel = 1'b1;
    @(negedge clk);
    rel = 1'b0;

    // Hold limit on MAX_HOLD=4 instance.
    wait_grant("to");
    cnt = 0;
    while (gv_a === 1'b1 && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    check("hold_len", cnt, 32'd4);
    check("to_pulse", {31'd0, to_a}, 32'd1);
    @(negedge clk);
    check("to_regrant_gv",  {31'd0, gv_a},  32'd1);
    check("to_regrant_idx", {29'd0, idx_a}, 32'd3);
    check("to_cleared",     {31'd0, to_a},  32'd0);

    // Owner 3 drops; then owner 2 drops mid-grant.
    req = 8'h04;
    @(negedge clk);
    check("drop3_gv", {31'd0, gv_a}, 32'd0);
    check("drop3_to", {31'd0, to_a}, 32'd0);
    @(negedge clk);
    check("own2_idx", {29'd0, idx_a}, 32'd2);
    @(negedge clk);
    req = 8'h00;
    @(negedge clk);
    check("drop2_gv", {31'd0, gv_a}, 32'd0);
    check("drop2_to", {31'd0, to_a}, 32'd0);

    // Release on the same edge as the hold limit.
    req = 8'h04;
    @(negedge clk);
    check("sim_gv", {31'd0, gv_a}, 32'd1);
    repeat (3) @(negedge clk);
    check("sim_still", {31'd0, gv_a}, 32'd1);
    rel = 1'b1;
    @(negedge clk);
    rel = 1'b0;
    check("sim_end_gv", {31'd0, gv_a}, 32'd0);
    check("sim_end_to", {31'd0, to_a}, 32'd0);

    // Asynchronous reset mid-grant of owner 5.
    req = 8'h20;
    @(negedge clk);
    check("own5_idx", {29'd0, idx_a}, 32'd5);
    #2 rst_n = 1'b0;
    #1;
    check("async_gv_a", {31'd0, gv_a}, 32'd0);
    check("async_gv_b", {31'd0, gv_b}, 32'd0);
    req = 8'h21;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_gv",  {31'd0, gv_a},  32'd1);
    check("post_rst_idx", {29'd0, idx_a}, 32'd0);

    // Randomized traffic against the model, with occasional async resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) req = 8'($urandom);
      rel = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 399) == 0) begin
        #3 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
